// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: I/D block fills and D write-through stores,
// with a fixed-latency read return pipeline tagging each word with its block offset.
module mem_arbiter #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic        fill_valid,
    output logic        fill_dst,
    output logic [2:0]  fill_offset,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

    state_t      state, state_nxt;
    logic        owner;      // 1 = D side
    logic        prio;       // 1 = D side holds priority
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  cnt;
    logic        issue;
    logic        pick_d;
    logic [15:0] sel_addr;

    logic [LATENCY-1:0] pv;
    logic [2:0]         po [LATENCY];

    assign busy        = (state != IDLE);
    assign fill_valid  = pv[LATENCY-1];
    assign fill_dst    = fill_valid & owner;
    assign fill_offset = fill_valid ? po[LATENCY-1] : '0;
    assign fill_data   = fill_valid ? mem_rdata : '0;

    always_comb begin
        state_nxt  = state;
        i_grant    = 1'b0;
        d_grant    = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        issue      = 1'b0;
        pick_d     = d_req && (!i_req || prio);
        sel_addr   = pick_d ? d_addr : i_addr;

        case (state)
            IDLE: begin
                // grants are combinational, so hold them off while reset is asserted
                if (rst_n && (i_req || d_req)) begin
                    i_grant   = !pick_d;
                    d_grant   = pick_d;
                    state_nxt = (pick_d && d_wr) ? WRITE : ISSUE;
                end
            end
            ISSUE: begin
                mem_enable = 1'b1;
                mem_addr   = {addr_q[15:4], cnt, 1'b0};
                issue      = 1'b1;
                if (cnt == 3'd7) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fill_valid && (fill_offset == 3'd7)) begin
                    i_done    = !owner;
                    d_done    = owner;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                d_done     = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            prio    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            pv      <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) po[i] <= '0;
        end else begin
            state <= state_nxt;
            if (i_grant || d_grant) begin
                owner   <= d_grant;
                addr_q  <= sel_addr & 16'hFFFE;
                wdata_q <= d_wdata;
                cnt     <= '0;
            end else if (issue) begin
                cnt <= cnt + 3'd1;
            end
            if (i_done || d_done) prio <= ~owner;
            // one stage per cycle of memory latency; stage LATENCY-1 lines up with mem_rdata
            pv[0] <= issue;
            po[0] <= cnt;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants, memory
// accesses, fill words and done pulses; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: LATENCY=4, instance B: LATENCY=1
    logic        i_req_a = 0, d_req_a = 0, d_wr_a = 0;
    logic [15:0] i_addr_a = '0, d_addr_a = '0, d_wdata_a = '0;
    logic        i_grant_a, d_grant_a, fill_valid_a, fill_dst_a, i_done_a, d_done_a;
    logic        mem_enable_a, mem_wr_a, busy_a;
    logic [2:0]  fill_offset_a;
    logic [15:0] fill_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

    logic        i_req_b = 0, d_req_b = 0, d_wr_b = 0;
    logic [15:0] i_addr_b = '0, d_addr_b = '0, d_wdata_b = '0;
    logic        i_grant_b, d_grant_b, fill_valid_b, fill_dst_b, i_done_b, d_done_b;
    logic        mem_enable_b, mem_wr_b, busy_b;
    logic [2:0]  fill_offset_b;
    logic [15:0] fill_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_arbiter #(.LATENCY(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req_a), .i_addr(i_addr_a),
        .d_req(d_req_a), .d_wr(d_wr_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .i_grant(i_grant_a), .d_grant(d_grant_a),
        .fill_valid(fill_valid_a), .fill_dst(fill_dst_a),
        .fill_offset(fill_offset_a), .fill_data(fill_data_a),
        .i_done(i_done_a), .d_done(d_done_a),
        .mem_enable(mem_enable_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
    );

    mem_arbiter #(.LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req_b), .i_addr(i_addr_b),
        .d_req(d_req_b), .d_wr(d_wr_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .i_grant(i_grant_b), .d_grant(d_grant_b),
        .fill_valid(fill_valid_b), .fill_dst(fill_dst_b),
        .fill_offset(fill_offset_b), .fill_data(fill_data_b),
        .i_done(i_done_b), .d_done(d_done_b),
        .mem_enable(mem_enable_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    // memory models: word at address A reads back as A ^ 16'hA5A5 after the latency
    logic [15:0] dl_a [4];
    logic [15:0] dl_b [1];
    always @(posedge clk) begin
        dl_a[0] <= mem_addr_a;
        for (int i = 1; i < 4; i++) dl_a[i] <= dl_a[i-1];
        dl_b[0] <= mem_addr_b;
    end
    assign mem_rdata_a = dl_a[3] ^ 16'hA5A5;
    assign mem_rdata_b = dl_b[0] ^ 16'hA5A5;

    logic [59:0] outs_a, outs_b;
    assign outs_a = {i_grant_a, d_grant_a, fill_valid_a, fill_dst_a, fill_offset_a, fill_data_a,
                     i_done_a, d_done_a, mem_enable_a, mem_wr_a, mem_addr_a, mem_wdata_a, busy_a};
    assign outs_b = {i_grant_b, d_grant_b, fill_valid_b, fill_dst_b, fill_offset_b, fill_data_b,
                     i_done_b, d_done_b, mem_enable_b, mem_wr_b, mem_addr_b, mem_wdata_b, busy_b};

    typedef struct {
        int          inst;
        int          cyc;
        logic        b;
        logic [2:0]  off;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t q_gnt[$], q_mem[$], q_fill[$], q_done[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic unexp(input string name);
        n_total++;
        $display("FAIL %s: output present at cycle %0d, none expected", name, cyc);
    endtask

    function automatic ev_t mk(input int inst, input int c, input logic b,
                               input logic [2:0] off, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.inst = inst; e.cyc = c; e.b = b; e.off = off; e.a = a; e.d = d;
        return e;
    endfunction

    task automatic exp_fill(input int inst, input logic dst, input logic [15:0] addr,
                            input int t0, input int lat);
        logic [15:0] base;
        logic [15:0] wa;
        base = {addr[15:4], 4'h0};
        q_gnt.push_back(mk(inst, t0, dst, 3'd0, '0, '0));
        for (int k = 0; k < 8; k++) begin
            wa = base + 16'(2 * k);
            q_mem.push_back(mk(inst, t0 + 1 + k, 1'b0, 3'd0, wa, 16'h0000));
            q_fill.push_back(mk(inst, t0 + 1 + k + lat, dst, 3'(k), '0, wa ^ 16'hA5A5));
        end
        q_done.push_back(mk(inst, t0 + 8 + lat, dst, 3'd0, '0, '0));
    endtask

    task automatic exp_write(input int inst, input logic [15:0] addr, input logic [15:0] data,
                             input int t0);
        q_gnt.push_back(mk(inst, t0, 1'b1, 3'd0, '0, '0));
        q_mem.push_back(mk(inst, t0 + 1, 1'b1, 3'd0, {addr[15:1], 1'b0}, data));
        q_done.push_back(mk(inst, t0 + 1, 1'b1, 3'd0, '0, '0));
    endtask

    task automatic mon(input int inst, input logic ig, input logic dg,
                       input logic me, input logic mw, input logic [15:0] ma, input logic [15:0] mwd,
                       input logic fv, input logic fd, input logic [2:0] fo, input logic [15:0] fdat,
                       input logic idn, input logic ddn);
        ev_t e;
        if (ig || dg) begin
            if (q_gnt.size() != 0 && q_gnt[0].inst == inst) begin
                e = q_gnt.pop_front();
                chk($sformatf("grant%0d", inst), {cyc[15:0], ig, dg}, {e.cyc[15:0], ~e.b, e.b});
            end else unexp($sformatf("grant%0d", inst));
        end
        if (me) begin
            if (q_mem.size() != 0 && q_mem[0].inst == inst) begin
                e = q_mem.pop_front();
                chk($sformatf("mem%0d", inst), {cyc[15:0], mw, ma, mwd}, {e.cyc[15:0], e.b, e.a, e.d});
            end else unexp($sformatf("mem%0d", inst));
        end else chk($sformatf("mem_idle%0d", inst), {mw, ma, mwd}, '0);
        if (fv) begin
            if (q_fill.size() != 0 && q_fill[0].inst == inst) begin
                e = q_fill.pop_front();
                chk($sformatf("fill%0d", inst), {cyc[15:0], fd, fo, fdat}, {e.cyc[15:0], e.b, e.off, e.d});
            end else unexp($sformatf("fill%0d", inst));
        end else chk($sformatf("fill_idle%0d", inst), {fd, fo, fdat}, '0);
        if (idn || ddn) begin
            if (q_done.size() != 0 && q_done[0].inst == inst) begin
                e = q_done.pop_front();
                chk($sformatf("done%0d", inst), {cyc[15:0], idn, ddn}, {e.cyc[15:0], ~e.b, e.b});
            end else unexp($sformatf("done%0d", inst));
        end
    endtask

    always @(negedge clk) begin
        mon(0, i_grant_a, d_grant_a, mem_enable_a, mem_wr_a, mem_addr_a, mem_wdata_a,
            fill_valid_a, fill_dst_a, fill_offset_a, fill_data_a, i_done_a, d_done_a);
        mon(1, i_grant_b, d_grant_b, mem_enable_b, mem_wr_b, mem_addr_b, mem_wdata_b,
            fill_valid_b, fill_dst_b, fill_offset_b, fill_data_b, i_done_b, d_done_b);
    end

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_a", outs_a, '0);
        chk("reset_outs_b", outs_b, '0);
        rst_n = 1'b1;

        // simultaneous requests after reset: D first, then I
        c0 = cyc;
        d_req_a = 1; d_wr_a = 0; d_addr_a = 16'h2468;
        i_req_a = 1; i_addr_a = 16'h1234;
        exp_fill(0, 1'b1, 16'h2468, c0, 4);
        exp_fill(0, 1'b0, 16'h1234, c0 + 13, 4);
        step_to(c0 + 1);  d_req_a = 0;
        step_to(c0 + 14); i_req_a = 0;
        step_to(c0 + 26);

        // D write-through store
        c0 = cyc;
        d_req_a = 1; d_wr_a = 1; d_addr_a = 16'h0101; d_wdata_a = 16'hBEEF;
        exp_write(0, 16'h0101, 16'hBEEF, c0);
        step_to(c0 + 1); d_req_a = 0; d_wr_a = 0;
        step_to(c0 + 2);
        chk("write_idle_t2", {31'd0, busy_a}, '0);

        // I fill from idle
        c0 = cyc;
        i_req_a = 1; i_addr_a = 16'h1234;
        exp_fill(0, 1'b0, 16'h1234, c0, 4);
        step_to(c0 + 1); i_req_a = 0;
        step_to(c0 + 12);
        chk("fill_busy_t12", {31'd0, busy_a}, 64'd1);
        step_to(c0 + 13);
        chk("fill_idle_t13", {31'd0, busy_a}, '0);

        // continuous contention: D fill, I fill, D write, I fill
        c0 = cyc;
        d_req_a = 1; d_wr_a = 0; d_addr_a = 16'h4000;
        i_req_a = 1; i_addr_a = 16'h8010;
        exp_fill(0, 1'b1, 16'h4000, c0, 4);
        exp_fill(0, 1'b0, 16'h8010, c0 + 13, 4);
        exp_write(0, 16'h5006, 16'hCAFE, c0 + 26);
        exp_fill(0, 1'b0, 16'h9020, c0 + 28, 4);
        step_to(c0 + 1);  d_wr_a = 1; d_addr_a = 16'h5006; d_wdata_a = 16'hCAFE;
        step_to(c0 + 14); i_addr_a = 16'h9020;
        step_to(c0 + 27); d_req_a = 0; d_wr_a = 0;
        step_to(c0 + 29); i_req_a = 0;
        step_to(c0 + 41);

        // reset in the middle of a D fill, after offsets 0..1 have returned
        c0 = cyc;
        d_req_a = 1; d_wr_a = 0; d_addr_a = 16'h3000;
        exp_fill(0, 1'b1, 16'h3000, c0, 4);
        step_to(c0 + 1); d_req_a = 0;
        step_to(c0 + 7);
        q_gnt.delete(); q_mem.delete(); q_fill.delete(); q_done.delete();
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs_a, '0);
        step_to(c0 + 9); rst_n = 1'b1;
        step_to(c0 + 13);
        chk("post_reset_idle", {31'd0, busy_a}, '0);
        c0 = cyc;
        d_req_a = 1; d_addr_a = 16'h3000;
        i_req_a = 1; i_addr_a = 16'h7008;
        exp_fill(0, 1'b1, 16'h3000, c0, 4);
        exp_fill(0, 1'b0, 16'h7008, c0 + 13, 4);
        step_to(c0 + 1);  d_req_a = 0;
        step_to(c0 + 14); i_req_a = 0;
        step_to(c0 + 26);

        // LATENCY=1 instance: I fill at 0x0000
        c0 = cyc;
        i_req_b = 1; i_addr_b = 16'h0000;
        exp_fill(1, 1'b0, 16'h0000, c0, 1);
        step_to(c0 + 1); i_req_b = 0;
        step_to(c0 + 12);

        chk("pending_grants", 64'(q_gnt.size()), '0);
        chk("pending_mem", 64'(q_mem.size()), '0);
        chk("pending_fills", 64'(q_fill.size()), '0);
        chk("pending_dones", 64'(q_done.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port main memory between two requesters: the instruction-cache miss handler (I side) and the data-cache miss/store handler (D side).
- Serves 8-word block fills to either side and single-word write-through stores from the D side.
- Sequences the memory address stream and tracks the fixed-latency read data.
- Routes returned words to the owning requester with their block offsets.

Parameters:
LATENCY, 4, main-memory read latency in cycles from address issue to mem_rdata valid (legal range 1..8)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_req  input  1  I-side block-fill request
i_addr  input  16  I-side miss byte address
d_req  input  1  D-side request
d_wr  input  1  D-side request type: 1=single-word write, 0=block fill
d_addr  input  16  D-side byte address
d_wdata  input  16  D-side store data
i_grant  output  1  one-cycle pulse: I request accepted
d_grant  output  1  one-cycle pulse: D request accepted
fill_valid  output  1  fill_data valid this cycle
fill_dst  output  1  owner of fill word: 0=I, 1=D
fill_offset  output  3  word index within block (0..7)
fill_data  output  16  returned word (copy of mem_rdata)
i_done  output  1  one-cycle pulse: I fill complete
d_done  output  1  one-cycle pulse: D fill or write complete
mem_enable  output  1  memory access this cycle
mem_wr  output  1  memory write strobe
mem_addr  output  16  memory byte address
mem_wdata  output  16  memory write data
mem_rdata  input  16  memory read data, valid LATENCY cycles after its address issue
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, all outputs 0, priority pointer = D, the in-flight valid pipeline is cleared, and any in-flight data is discarded. This applies mid-operation as well; no done pulse is produced for an aborted transaction.
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE, arbitration:
  - If exactly one request is asserted, grant it.
  - If both are asserted, grant the side holding priority.
  - The grant pulse is asserted in the IDLE cycle itself (cycle t0).
  - Latch: owner, type, block base = {addr[15:4],4'h0}, word address = {addr[15:1],1'b0}, and d_wdata.
  - Next state: WRITE for a D write, ISSUE otherwise.
  - An I request is always a fill; d_wr is ignored when the I side is granted.
- Requesters hold req (and addr/data) stable until their grant, then deassert it in the following cycle. A req that is high while busy is pending and is not lost.
- ISSUE:
  - 8 consecutive cycles t1..t8, k=0..7.
  - mem_enable=1, mem_wr=0, mem_addr = base + (k<<1).
  - A 3-bit issue counter advances each cycle; after k=7, next state is DRAIN.
- Return path:
  - A LATENCY-deep shift pipeline carries {valid, offset} per issued address.
  - fill_valid is asserted in cycle t(k+1)+LATENCY, with fill_offset=k, fill_dst=owner, fill_data=mem_rdata (combinational pass-through).
- DRAIN:
  - mem_enable=0.
  - Wait for offset 7 to return. In the cycle offset 7 returns (t8+LATENCY), fill_valid and the owner's done pulse are both asserted, and next state is IDLE.
  - The earliest next grant is t9+LATENCY. Fills never overlap.
- WRITE:
  - Single cycle t1: mem_enable=1, mem_wr=1, mem_addr = latched word address, mem_wdata = latched data.
  - d_done pulses in the same cycle; next state is IDLE. No fill_valid is produced.
- Priority:
  - After any transaction completes, priority passes to the side that was not just served, even if that side is idle.
  - Under continuous contention, service strictly alternates.
- Outputs not driven by the current state are 0: mem_addr=0 and mem_wdata=0 when mem_enable=0, and fill_* = 0 when fill_valid=0.
- busy is high in ISSUE, DRAIN and WRITE.

Test Plan:
1. LATENCY=4; i_req with i_addr=0x1234 at t0 -> i_grant at t0; mem_addr 0x1230,0x1232,...,0x123E at t1..t8; fill_valid with fill_dst=0 and offsets 0..7 at t5..t12; i_done at t12 only; busy low at t13.
2. After reset, i_req and d_req asserted together -> d_grant at t0; d_done at t12; i_grant at t13.
3. D write with d_addr=0x0101, d_wdata=0xBEEF -> d_grant t0; at t1 mem_enable=1, mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF, d_done=1; no fill_valid; idle at t2.
4. Both sides re-request immediately after every grant, for 4 transactions -> grant order D, I, D, I; every fill's fill_dst matches its owner.
5. rst_n driven low at t7 of a D fill (offsets 0..1 already returned) -> all outputs 0 asynchronously; no d_done; after release with no requests, stays IDLE; on simultaneous requests, D is granted first.
6. LATENCY=1 build; I fill at 0x0000 -> fills at t2..t9 with offsets 0..7; i_done at t9.
